// File: rtl/draw_wall_column_if.sv
// Request/response and VGA pixel-write bundle between the draw_fpv controller and the column renderer.
// The controller side is the master; the renderer side is the slave.
interface draw_wall_column_if;
    logic        start;
    logic [7:0]  x;
    logic [6:0]  wall_height;
    logic [17:0] wall_colour;
    logic        busy;
    logic        done;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;

    modport master (
        output start, x, wall_height, wall_colour,
        input  busy, done, vga_x, vga_y, vga_colour, vga_write
    );

    modport slave (
        input  start, x, wall_height, wall_colour,
        output busy, done, vga_x, vga_y, vga_colour, vga_write
    );
endinterface

// File: rtl/draw_wall_column.sv
// Column renderer: writes one screen column of ceiling, a centred wall slice and floor,
// one registered VGA pixel per cycle, then pulses done.
module draw_wall_column #(
    parameter int          SCREEN_H     = 120,
    parameter logic [17:0] CEIL_COLOUR  = 18'h0,
    parameter logic [17:0] FLOOR_COLOUR = 18'h15555
) (
    input logic               clock,
    input logic               reset,
    draw_wall_column_if.slave bus
);

    localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);
    localparam logic [7:0] HALF_H    = 8'(SCREEN_H / 2);
    localparam logic [6:0] LAST_Y    = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  y_q, y_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  h_q, h_d;
    logic [17:0] colour_q, colour_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        write_q, write_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [17:0] vga_colour_q, vga_colour_d;

    logic [7:0]  h_c;
    logic [7:0]  top;
    logic [7:0]  bot;

    // Slice bounds follow the latched height; 8-bit maths keeps bot <= SCREEN_H without wrapping.
    always_comb begin
        h_c = ({1'b0, h_q} > SCREEN_H8) ? SCREEN_H8 : {1'b0, h_q};
        top = HALF_H - (h_c >> 1);
        bot = top + h_c;
    end

    function automatic logic [17:0] row_colour(input logic [6:0] row, input logic [7:0] top_r,
                                               input logic [7:0] bot_r, input logic [17:0] wall_r);
        if ({1'b0, row} < top_r)
            return CEIL_COLOUR;
        else if ({1'b0, row} < bot_r)
            return wall_r;
        else
            return FLOOR_COLOUR;
    endfunction

    // Outputs are computed for the next state so they leave the flops aligned with it.
    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        x_d          = x_q;
        h_d          = h_q;
        colour_d     = colour_q;
        done_d       = 1'b0;
        write_d      = 1'b0;
        vga_y_d      = 7'd0;
        vga_colour_d = 18'd0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SETUP;
                    x_d      = bus.x;
                    h_d      = bus.wall_height;
                    colour_d = bus.wall_colour;
                end
            end
            SETUP: begin
                state_d      = DRAW;
                y_d          = 7'd0;
                write_d      = 1'b1;
                vga_y_d      = 7'd0;
                vga_colour_d = row_colour(7'd0, top, bot, colour_q);
            end
            DRAW: begin
                if (y_q == LAST_Y) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    y_d          = y_q + 7'd1;
                    write_d      = 1'b1;
                    vga_y_d      = y_d;
                    vga_colour_d = row_colour(y_d, top, bot, colour_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SETUP) || (state_d == DRAW);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            y_q          <= 7'd0;
            x_q          <= 8'd0;
            h_q          <= 7'd0;
            colour_q     <= 18'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            write_q      <= 1'b0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 18'd0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            x_q          <= x_d;
            h_q          <= h_d;
            colour_q     <= colour_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            write_q      <= write_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.vga_x      = x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_write  = write_q;

endmodule

// File: tb/tb_draw_wall_column.sv
// Directed bench for draw_wall_column: whole columns checked pixel by pixel against
// hand-derived slice bounds, plus ignored starts, mid-column reset and back-to-back requests.
module tb_draw_wall_column;

    localparam logic [17:0] CEIL  = 18'h0;
    localparam logic [17:0] FLOOR = 18'h15555;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    draw_wall_column_if bus ();

    draw_wall_column dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {18'd0, bus.busy, bus.done, bus.vga_write, bus.vga_x, bus.vga_y, bus.vga_colour};
    endfunction

    // Starts one column and follows it to done; top/bot are the hand-computed wall rows.
    task automatic applyStimulus(input string tag, input logic [7:0] cx, input logic [6:0] ch,
                                 input logic [17:0] cc, input int top, input int bot, input bit glitch);
        int writes = 0;
        int first_write = -1;
        int done_cycle = -1;
        logic [17:0] exp_colour;
        bus.start       = 1'b1;
        bus.x           = cx;
        bus.wall_height = ch;
        bus.wall_colour = cc;
        tick();
        bus.start       = 1'b0;
        bus.x           = ~cx;
        bus.wall_height = ~ch;
        bus.wall_colour = ~cc;
        checkOutput({tag, " setup"}, {61'd0, bus.busy, bus.done, bus.vga_write}, 64'b100);
        for (int k = 1; k < 200 && done_cycle < 0; k++) begin
            if (bus.vga_write) begin
                exp_colour = (writes < top) ? CEIL : ((writes < bot) ? cc : FLOOR);
                checkOutput($sformatf("%s pixel %0d", tag, writes),
                            {28'd0, bus.busy, bus.done, bus.vga_x, bus.vga_y, bus.vga_colour},
                            {28'd0, 1'b1, 1'b0, cx, 7'(writes), exp_colour});
                if (first_write < 0) first_write = k;
                writes++;
            end
            if (bus.done) done_cycle = k;
            if (done_cycle < 0) begin
                bus.start = glitch && (k + 1 == 5 || k + 1 == 60);
                bus.x     = 8'd99;
                bus.wall_height = 7'd10;
                bus.wall_colour = 18'h00FFF;
                tick();
            end
        end
        bus.start = 1'b0;
        checkOutput({tag, " writes"}, 64'(writes), 64'd120);
        checkOutput({tag, " first write cycle"}, 64'(first_write), 64'd2);
        checkOutput({tag, " done cycle"}, 64'(done_cycle), 64'd122);
        checkOutput({tag, " done state"}, {61'd0, bus.busy, bus.vga_write, bus.done}, 64'b001);
    endtask

    initial begin
        int writes;
        int dones;
        bus.start       = 1'b0;
        bus.x           = 8'd0;
        bus.wall_height = 7'd0;
        bus.wall_colour = 18'd0;
        reset = 1'b1;
        tick();
        tick();
        checkOutput("reset state", all_outputs(), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("idle after reset", all_outputs(), 64'd0);

        $display("[TB] basic column and height boundaries");
        applyStimulus("h40", 8'd37, 7'd40, 18'h3F000, 40, 80, 1'b0);
        tick();
        applyStimulus("h0", 8'd5, 7'd0, 18'h2A2A2, 60, 60, 1'b0);
        tick();
        applyStimulus("h127", 8'd250, 7'd127, 18'h0F0F0, 0, 120, 1'b0);
        tick();
        applyStimulus("h1", 8'd1, 7'd1, 18'h3FFFF, 60, 61, 1'b0);
        tick();
        applyStimulus("h5", 8'd159, 7'd5, 18'h12345, 58, 63, 1'b0);
        tick();

        $display("[TB] starts during a column are ignored");
        applyStimulus("glitch", 8'd12, 7'd20, 18'h00F0F, 50, 70, 1'b1);
        writes = 0;
        dones  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            writes += int'(bus.vga_write);
            dones  += int'(bus.done);
        end
        checkOutput("glitch no extra activity", {32'(writes), 32'(dones)}, 64'd0);

        $display("[TB] reset mid-column");
        bus.start       = 1'b1;
        bus.x           = 8'd77;
        bus.wall_height = 7'd30;
        bus.wall_colour = 18'h3C3C3;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 50; k++) tick();
        checkOutput("pre-reset pixel", {46'd0, bus.vga_write, bus.vga_y, 10'd0}, {46'd0, 1'b1, 7'd48, 10'd0});
        reset = 1'b1;
        tick();
        checkOutput("reset aborts column", all_outputs(), 64'd0);
        reset = 1'b0;
        writes = 0;
        dones  = 0;
        for (int i = 0; i < 130; i++) begin
            tick();
            writes += int'(bus.vga_write);
            dones  += int'(bus.done) + int'(bus.busy);
        end
        checkOutput("no activity after reset", {32'(writes), 32'(dones)}, 64'd0);
        applyStimulus("after reset", 8'd77, 7'd30, 18'h3C3C3, 45, 75, 1'b0);
        tick();

        $display("[TB] back-to-back columns");
        applyStimulus("b2b first", 8'd200, 7'd60, 18'h11111, 30, 90, 1'b0);
        tick();
        applyStimulus("b2b second", 8'd201, 7'd61, 18'h22222, 30, 91, 1'b0);
        tick();
        checkOutput("final idle", all_outputs(), {18'd0, 3'b000, 8'd201, 7'd0, 18'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
